// File: rtl/coax_rx_buffer.sv
// Receive-side frame buffer for the coax receiver: captures one frame of 10-bit words into a
// FIFO, latches frame status and offers a pull-style read port with one cycle of read latency.
module coax_rx_buffer #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_active_i,
  input  logic                   rx_error_i,
  input  logic [9:0]             rx_data_i,
  input  logic                   rx_strobe_i,
  output logic                   rx_reset_o,
  input  logic                   clear_i,
  input  logic                   read_strobe_i,
  output logic [9:0]             read_data_o,
  output logic                   read_valid_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   frame_done_o,
  output logic                   frame_error_o,
  output logic [9:0]             error_code_o,
  output logic                   overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StReceiving, StDone, StError} state_e;

  state_e state_q, state_d;
  logic   receiving;
  logic   active_prev_q;
  logic   active_rise;

  logic [9:0]             mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [9:0]             read_data_q;
  logic                   read_valid_q;
  logic                   frame_done_q, frame_error_q, overflow_q, rx_reset_q;
  logic [9:0]             error_code_q;
  logic                   wr_en, rd_en, wr_drop;

  assign active_rise = rx_active_i & ~active_prev_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state; clear dominates every state
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:      if (active_rise) state_d = StReceiving;
        StReceiving: begin
          if (rx_error_i)        state_d = StError;
          else if (!rx_active_i) state_d = StDone;
        end
        StDone:      state_d = StDone;
        StError:     state_d = StError;
        default:     state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    receiving = (state_q == StReceiving);
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == COUNT_WIDTH'(DEPTH));

  // Full is judged on the registered count, so a pop in the same cycle cannot make room
  assign wr_en   = receiving & rx_strobe_i & ~full_o & ~clear_i;
  assign wr_drop = receiving & rx_strobe_i & full_o & ~clear_i;
  assign rd_en   = read_strobe_i & ~empty_o & ~clear_i;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + COUNT_WIDTH'(1);
        2'b01:   count_d = count_q - COUNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_prev_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      read_data_q   <= '0;
      read_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      error_code_q  <= '0;
      overflow_q    <= 1'b0;
      rx_reset_q    <= 1'b1;
    end else begin
      active_prev_q <= rx_active_i;
      count_q       <= count_d;
      read_valid_q  <= rd_en;
      rx_reset_q    <= clear_i;
      if (rd_en) read_data_q <= mem_q[rd_ptr_q];
      if (clear_i) begin
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        frame_done_q  <= 1'b0;
        frame_error_q <= 1'b0;
        error_code_q  <= '0;
        overflow_q    <= 1'b0;
      end else begin
        if (wr_en)   wr_ptr_q   <= wr_ptr_q + PtrW'(1);
        if (rd_en)   rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        if (wr_drop) overflow_q <= 1'b1;
        if (receiving) begin
          if (rx_error_i) begin
            frame_error_q <= 1'b1;
            error_code_q  <= rx_data_i;
          end else if (!rx_active_i) begin
            frame_done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign count_o       = count_q;
  assign read_data_o   = read_data_q;
  assign read_valid_o  = read_valid_q;
  assign frame_done_o  = frame_done_q;
  assign frame_error_o = frame_error_q;
  assign error_code_o  = error_code_q;
  assign overflow_o    = overflow_q;
  assign rx_reset_o    = rx_reset_q;

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Scoreboard bench for coax_rx_buffer: a queue-based frame model predicts status and read data,
// a separate monitor checks every read_valid pulse against the expected-data queue.
module tb_coax_rx_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam int MIdle = 0, MRcv = 1, MDone = 2, MErr = 3;

  logic          clk, reset;
  logic          rx_active, rx_error, rx_strobe, rx_reset;
  logic [9:0]    rx_data;
  logic          clear, read_strobe;
  logic [9:0]    read_data;
  logic          read_valid, empty, full;
  logic [CW-1:0] count;
  logic          frame_done, frame_error, overflow;
  logic [9:0]    error_code;

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_active_i  (rx_active),
    .rx_error_i   (rx_error),
    .rx_data_i    (rx_data),
    .rx_strobe_i  (rx_strobe),
    .rx_reset_o   (rx_reset),
    .clear_i      (clear),
    .read_strobe_i(read_strobe),
    .read_data_o  (read_data),
    .read_valid_o (read_valid),
    .empty_o      (empty),
    .full_o       (full),
    .count_o      (count),
    .frame_done_o (frame_done),
    .frame_error_o(frame_error),
    .error_code_o (error_code),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame contents as a queue, status as plain flags
  int mq[$];
  int exp_q[$];
  int m_st, m_ecode, m_rd;
  bit m_done, m_ferr, m_ovf, m_rv, m_prev, m_rxr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got data %0d with nothing expected at %0t",
                 read_data, $time);
      end else begin
        chk("rd_data", int'(read_data), exp_q.pop_front());
      end
    end
  end

  task automatic cycle(input bit rst, input bit act, input bit err, input bit stb,
                       input bit [9:0] d, input bit clr, input bit rd);
    bit rd_ok, wr_ok;
    reset = rst; rx_active = act; rx_error = err; rx_strobe = stb;
    rx_data = d; clear = clr; read_strobe = rd;
    if (rst) begin
      mq.delete();
      m_st = MIdle; m_done = 0; m_ferr = 0; m_ecode = 0; m_ovf = 0;
      m_rv = 0; m_rd = 0; m_prev = 0; m_rxr = 1;
    end else begin
      rd_ok = rd && mq.size() > 0 && !clr;
      wr_ok = m_st == MRcv && stb && mq.size() < DEPTH && !clr;
      if (m_st == MRcv && stb && mq.size() == DEPTH && !clr) m_ovf = 1;
      m_rv = rd_ok;
      if (rd_ok) begin
        m_rd = mq.pop_front();
        exp_q.push_back(m_rd);
      end
      if (wr_ok) mq.push_back(int'(d));
      if (clr) begin
        mq.delete();
        m_st = MIdle; m_done = 0; m_ferr = 0; m_ecode = 0; m_ovf = 0;
      end else begin
        case (m_st)
          MIdle: if (act && !m_prev) m_st = MRcv;
          MRcv: begin
            if (err) begin
              m_st = MErr; m_ferr = 1; m_ecode = int'(d);
            end else if (!act) begin
              m_st = MDone; m_done = 1;
            end
          end
          default: ;
        endcase
      end
      m_prev = act;
      m_rxr  = clr;
    end
    @(posedge clk);
    @(negedge clk);
    chk("count", int'(count), mq.size());
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("frame_error", int'(frame_error), int'(m_ferr));
    chk("error_code", int'(error_code), m_ecode);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("rx_reset", int'(rx_reset), int'(m_rxr));
    chk("read_valid", int'(read_valid), int'(m_rv));
    chk("read_data_hold", int'(read_data), m_rd);
  endtask

  task automatic idle(input bit act);
    cycle(0, act, 0, 0, 10'h000, 0, 0);
  endtask

  task automatic push(input bit [9:0] d);
    cycle(0, 1, 0, 1, d, 0, 0);
  endtask

  task automatic pop(input bit act);
    cycle(0, act, 0, 0, 10'h000, 0, 1);
  endtask

  task automatic do_clear(input bit act, input bit err);
    cycle(0, act, err, 0, 10'h000, 1, 0);
  endtask

  initial begin
    bit act, err, stb, clr, rd;
    bit [9:0] d;
    cycle(1, 0, 0, 0, 10'h000, 0, 0);
    cycle(1, 0, 0, 0, 10'h000, 0, 0);
    idle(0);

    // Clean three-word frame, then drain
    idle(1);
    push(10'h001); push(10'h2AA); push(10'h3FF);
    idle(0);
    pop(0); pop(0); pop(0);
    idle(0);

    // Error frame: one good word, then error code 0x002; later strobes ignored
    do_clear(0, 0);
    idle(1);
    push(10'h155);
    cycle(0, 1, 1, 0, 10'h002, 0, 0);
    cycle(0, 1, 1, 1, 10'h0AA, 0, 0);
    cycle(0, 0, 1, 1, 10'h0BB, 0, 0);
    do_clear(0, 1);
    idle(0);
    idle(0);

    // Overflow: six words into a four-deep FIFO
    idle(1);
    for (int i = 1; i <= 6; i++) push(10'(i));
    idle(0);
    for (int i = 0; i < 5; i++) pop(0);
    idle(0);

    // Simultaneous push/pop at count 2, wrapping the pointers
    do_clear(0, 0);
    idle(1);
    push(10'h100); push(10'h101);
    for (int i = 2; i < 12; i++) cycle(0, 1, 0, 1, 10'(10'h100 + i), 0, 1);
    idle(0);
    pop(0); pop(0); pop(0);

    // Reset in the middle of a frame
    do_clear(0, 0);
    idle(1);
    push(10'h033);
    cycle(1, 1, 0, 1, 10'h044, 0, 1);
    idle(0);

    // Clear while a frame is in progress, then a fresh frame
    idle(1);
    push(10'h211);
    do_clear(1, 0);
    push(10'h222);
    idle(0);
    idle(1);
    push(10'h233);
    idle(0);
    pop(0); pop(0);

    // Randomized traffic
    act = 0; err = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) act = !act;
      if (act && !err && $urandom_range(0, 60) == 0) err = 1;
      stb = 1'($urandom_range(0, 1));
      rd  = (n < 1500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 60) == 0);
      d   = 10'($urandom);
      cycle(($urandom_range(0, 999) == 0), act, err, stb, d, clr, rd);
      if (clr) err = 0;
    end
    idle(0);
    idle(0);
    chk("exp_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
